quad_root_avg: RTL
==================

// Module: quad_root_avg
// PURPOSE
//  Downstream stage of the 2-antenna DoA quadratic root solver: consumes the
//  root pair (x1,x2) with its dout_valid and integrates 2**ACC_LEN_LOG2 valid
//  root pairs into a per-root mean. Samples dropped upstream (negative
//  discriminant, no valid) leave gaps and are simply not counted.
//  Output feeds the angle LUT / readout register stage.
// PARAMETERS
//  DIN_WIDTH     8   root width, signed (matches solver SQRT_OUT_WIDTH)
//  DIN_POINT     5   root fractional bits; means keep the same format
//  ACC_LEN_LOG2  10  log2 of valid samples per integration, >=1
// PORTS
//  clk        in   1                        system clock
//  rst        in   1                        async reset, active-high
//  x1, x2     in   DIN_WIDTH signed         roots from solver
//  din_valid  in   1                        root pair valid
//  acc_clear  in   1                        sync restart of integration
//  mean1      out  DIN_WIDTH signed         rounded mean of x1
//  mean2      out  DIN_WIDTH signed         rounded mean of x2
//  dout_valid out  1                        1-cycle pulse, means updated
//  acc_cnt    out  ACC_LEN_LOG2             valid pairs in current integration
// BEHAVIOUR
//  - Reset (async, rst=1): all regs/outputs 0; takes effect mid-integration,
//    partial sums discarded; first frame after release starts at count 0.
//  - Pipeline: S0 registers x1,x2,din_valid; S1 accumulates into
//    ACC_W=DIN_WIDTH+ACC_LEN_LOG2 signed acc (cannot overflow);
//    S2 rounds and registers means. dout_valid 3 cycles after the
//    din_valid of the last sample of a frame.
//  - Count: acc_cnt increments per S0-valid, wraps ACC_LEN-1 -> 0.
//  - Dump: on the last sample, snapshot = acc + x, acc loads 0 same cycle;
//    the next sample (even back-to-back) starts the new frame; none lost.
//  - Rounding: mean = (snapshot + 2**(ACC_LEN_LOG2-1)) >>> ACC_LEN_LOG2,
//    round half toward +inf; result fits DIN_WIDTH by construction.
//  - mean1/mean2 hold between dout_valid pulses.
//  - acc_clear: zeroes acc, acc_cnt and pending S0 sample in one cycle;
//    priority over a coincident din_valid (sample discarded) and over a
//    coincident dump (no dout_valid); means keep last value.
//  - No back-pressure: consumer must accept every dout_valid pulse.
// CONFIGURATION
//  ROOT_AVG_SUMSQ_EN defined: adds outputs sumsq1,sumsq2
//   (2*DIN_WIDTH+ACC_LEN_LOG2, unsigned, point 2*DIN_POINT): sum of x**2
//   over the frame, square computed in S0, accumulated in S1, registered
//   with means, same dout_valid and latency, same clear/reset rules.
//  Not defined: ports, squarer and accumulators absent; latency unchanged.
// STRUCTURE
//  Package quad_root_avg_pkg: ACC_W, SUMSQ_W, ROUND_CONST, ACC_LEN widths.
//  Sub-module root_acc: one-channel accumulator + snapshot + rounding
//  (+ sum-of-squares under macro), instantiated for x1 and x2; counter and
//  clear/dump control live in the top.
// TESTING (ACC_LEN_LOG2=2, DIN_POINT=5 unless noted)
//  1 Assert rst mid-frame after 2 samples -> all outputs 0 immediately;
//    after release 4 samples of 32 -> exactly one dout_valid, mean1=32.
//  2 4 back-to-back pairs x1=32,x2=-32 -> dout_valid 3 cycles after 4th,
//    mean1=32, mean2=-32, acc_cnt back to 0.
//  3 Gapped valids x1=10,11,12,13; x2=-3,-3,-3,-2 -> mean1=12, mean2=-3.
//  4 8 back-to-back x1=1..8 -> two pulses, mean1=3 then 7; no sample lost.
//  5 2 samples of 100, acc_clear (with coincident din_valid of 100), then
//    4 samples of 4 -> single dout_valid, mean1=4.
//  6 ROOT_AVG_SUMSQ_EN, 4 pairs x1=-32,x2=16 -> sumsq1=4096, sumsq2=1024,
//    mean1=-32, same latency as without macro.

Source files
------------

// File: rtl/quad_root_avg_pkg.sv
// Shared sizing helpers for the quad_root_avg root-averaging stage.
// Widths depend on module parameters, so they are exposed as constant
// functions that the modules evaluate into their own localparams.
//   acc_w       : signed accumulator width, cannot overflow over a frame
//   sumsq_w     : unsigned sum-of-squares width
//   acc_len     : samples per integration frame
//   round_const : half-LSB of the mean, added before the final shift
package quad_root_avg_pkg;

  localparam int DEF_DIN_WIDTH    = 8;
  localparam int DEF_DIN_POINT    = 5;
  localparam int DEF_ACC_LEN_LOG2 = 10;

  function automatic int acc_w(input int din_width, input int len_log2);
    return din_width + len_log2;
  endfunction

  function automatic int sumsq_w(input int din_width, input int len_log2);
    return 2 * din_width + len_log2;
  endfunction

  function automatic int acc_len(input int len_log2);
    return 1 << len_log2;
  endfunction

  function automatic int round_const(input int len_log2);
    return 1 << (len_log2 - 1);
  endfunction

endpackage

// File: rtl/quad_root_avg_root_acc.sv
// root_acc: one-channel root integrator.
// Registers the incoming root (S0), accumulates it (S1), snapshots the
// frame sum on dump while restarting the accumulator in the same cycle,
// and produces the rounded mean (S2) on load.
// Optional macro ROOT_AVG_SUMSQ_EN adds a squarer in S0 and a parallel
// sum-of-squares accumulator with identical timing.
// Ports:
//   clk, rst   clock, async active-high reset
//   clear      restart integration (highest priority)
//   add        accumulate the S0 sample
//   dump       last sample of frame: snapshot acc + sample, zero acc
//   load       register rounded mean (and sumsq) from the snapshot
//   din        signed root input
//   mean       rounded signed mean, held between loads
//   sumsq      (macro only) unsigned frame sum of squares
module root_acc
  import quad_root_avg_pkg::*;
#(
  parameter int DIN_WIDTH    = DEF_DIN_WIDTH,
  parameter int ACC_LEN_LOG2 = DEF_ACC_LEN_LOG2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear,
  input  logic                        add,
  input  logic                        dump,
  input  logic                        load,
  input  logic signed [DIN_WIDTH-1:0] din,
  output logic signed [DIN_WIDTH-1:0] mean
`ifdef ROOT_AVG_SUMSQ_EN
  ,
  output logic [2*DIN_WIDTH+ACC_LEN_LOG2-1:0] sumsq
`endif
);

  localparam int ACC_W = acc_w(DIN_WIDTH, ACC_LEN_LOG2);
  localparam logic signed [ACC_W-1:0] ROUND_CONST = ACC_W'(round_const(ACC_LEN_LOG2));

  logic signed [DIN_WIDTH-1:0] s0_x;
  logic signed [ACC_W-1:0]     acc;
  logic signed [ACC_W-1:0]     snap;
  logic signed [ACC_W-1:0]     rnd;

  // Bias by half an LSB then arithmetic shift: round half toward +inf.
  assign rnd = snap + ROUND_CONST;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_x <= '0;
      acc  <= '0;
      snap <= '0;
      mean <= '0;
    end else begin
      s0_x <= din;
      if (clear) begin
        acc <= '0;
      end else if (dump) begin
        snap <= acc + ACC_W'(s0_x);
        acc  <= '0;
      end else if (add) begin
        acc <= acc + ACC_W'(s0_x);
      end
      if (load) begin
        mean <= DIN_WIDTH'(rnd >>> ACC_LEN_LOG2);
      end
    end
  end

`ifdef ROOT_AVG_SUMSQ_EN
  localparam int SQ_W = sumsq_w(DIN_WIDTH, ACC_LEN_LOG2);

  logic signed [2*DIN_WIDTH-1:0] sq_full;
  logic        [2*DIN_WIDTH-1:0] s0_sq;
  logic        [SQ_W-1:0]        sq_acc;
  logic        [SQ_W-1:0]        sq_snap;

  assign sq_full = (2*DIN_WIDTH)'(din) * (2*DIN_WIDTH)'(din);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_sq   <= '0;
      sq_acc  <= '0;
      sq_snap <= '0;
      sumsq   <= '0;
    end else begin
      s0_sq <= $unsigned(sq_full);
      if (clear) begin
        sq_acc <= '0;
      end else if (dump) begin
        sq_snap <= sq_acc + SQ_W'(s0_sq);
        sq_acc  <= '0;
      end else if (add) begin
        sq_acc <= sq_acc + SQ_W'(s0_sq);
      end
      if (load) begin
        sumsq <= sq_snap;
      end
    end
  end
`endif

endmodule

// File: rtl/quad_root_avg.sv
// quad_root_avg: integrates 2**ACC_LEN_LOG2 valid root pairs (x1,x2) from
// the DoA quadratic solver into per-root rounded means.
// Pipeline: S0 input register, S1 accumulate/snapshot, S2 mean register;
// dout_valid pulses 3 cycles after the din_valid of a frame's last sample.
// Optional macro ROOT_AVG_SUMSQ_EN adds sumsq1/sumsq2 outputs.
// Ports:
//   clk, rst        clock, async active-high reset
//   x1, x2          signed roots, din_valid qualifies the pair
//   acc_clear       synchronous restart of integration
//   mean1, mean2    rounded means, held between dout_valid pulses
//   dout_valid      1-cycle pulse when means update
//   acc_cnt         valid pairs accumulated in the current frame
//   sumsq1, sumsq2  (macro only) per-root frame sum of squares
module quad_root_avg
  import quad_root_avg_pkg::*;
#(
  parameter int DIN_WIDTH    = DEF_DIN_WIDTH,
  parameter int DIN_POINT    = DEF_DIN_POINT,
  parameter int ACC_LEN_LOG2 = DEF_ACC_LEN_LOG2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [DIN_WIDTH-1:0] x1,
  input  logic signed [DIN_WIDTH-1:0] x2,
  input  logic                        din_valid,
  input  logic                        acc_clear,
  output logic signed [DIN_WIDTH-1:0] mean1,
  output logic signed [DIN_WIDTH-1:0] mean2,
  output logic                        dout_valid,
  output logic [ACC_LEN_LOG2-1:0]     acc_cnt
`ifdef ROOT_AVG_SUMSQ_EN
  ,
  output logic [2*DIN_WIDTH+ACC_LEN_LOG2-1:0] sumsq1,
  output logic [2*DIN_WIDTH+ACC_LEN_LOG2-1:0] sumsq2
`endif
);

  localparam int ACC_LEN = acc_len(ACC_LEN_LOG2);

  if (ACC_LEN_LOG2 < 1) begin : g_bad_len
    $error("quad_root_avg: ACC_LEN_LOG2 must be >= 1");
  end
  if (DIN_POINT < 0 || DIN_POINT > DIN_WIDTH) begin : g_bad_point
    $error("quad_root_avg: DIN_POINT out of range");
  end

  logic s0_valid;
  logic dump_q;
  logic add;
  logic dump;

  // Clear outranks both the S0 sample and a coincident end-of-frame dump.
  assign add  = s0_valid & ~acc_clear;
  assign dump = add & (acc_cnt == ACC_LEN_LOG2'(ACC_LEN - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_valid   <= 1'b0;
      acc_cnt    <= '0;
      dump_q     <= 1'b0;
      dout_valid <= 1'b0;
    end else begin
      s0_valid <= din_valid & ~acc_clear;
      if (acc_clear) begin
        acc_cnt <= '0;
      end else if (s0_valid) begin
        acc_cnt <= acc_cnt + ACC_LEN_LOG2'(1);
      end
      dump_q     <= dump;
      dout_valid <= dump_q;
    end
  end

  root_acc #(
    .DIN_WIDTH   (DIN_WIDTH),
    .ACC_LEN_LOG2(ACC_LEN_LOG2)
  ) u_acc1 (
    .clk  (clk),
    .rst  (rst),
    .clear(acc_clear),
    .add  (add),
    .dump (dump),
    .load (dump_q),
    .din  (x1),
    .mean (mean1)
`ifdef ROOT_AVG_SUMSQ_EN
    ,
    .sumsq(sumsq1)
`endif
  );

  root_acc #(
    .DIN_WIDTH   (DIN_WIDTH),
    .ACC_LEN_LOG2(ACC_LEN_LOG2)
  ) u_acc2 (
    .clk  (clk),
    .rst  (rst),
    .clear(acc_clear),
    .add  (add),
    .dump (dump),
    .load (dump_q),
    .din  (x2),
    .mean (mean2)
`ifdef ROOT_AVG_SUMSQ_EN
    ,
    .sumsq(sumsq2)
`endif
  );

endmodule
